data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder that serves load/store requests issued by the MEM pipeline stage.
- Holds a word-addressed RAM and drives a `ready` handshake; the hazard/freeze logic uses `ready` to stall the pipeline.
- Lets the data memory model a slow SRAM instead of a zero-latency array.
- Sits between the MEM stage and the WB-stage read-data path.

---
 rtl/data_mem_responder.sv | 126 ++++++++++++
 tb/tb_data_mem_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle word-addressed data memory with ready handshake
// Serves one load/store at a time; every operand is latched in IDLE so the requester may change inputs while BUSY.
module data_mem_responder #(
  parameter int          WAIT_CYCLES = 3,
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        addr_err
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            store_q, store_d;
  logic            bad_q, bad_d;
  logic            both_q, both_d;
  logic [31:0]     read_data_q, read_data_d;
  logic            addr_err_q, addr_err_d;

  logic [31:0]     mem [DEPTH];
  logic            req;
  logic [31:0]     offset;
  logic            req_bad;
  logic            mem_we;

  always_comb begin
    req     = MEM_R_EN | MEM_W_EN;
    offset  = address - BASE_ADDR;
    // Unsigned wrap of offset alone cannot flag an address below base, so test it directly.
    req_bad = (address < BASE_ADDR) || ((offset >> 2) >= 32'(DEPTH)) || (address[1:0] != 2'b00);

    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    store_d     = store_q;
    bad_d       = bad_q;
    both_d      = both_q;
    read_data_d = read_data_q;
    addr_err_d  = 1'b0;
    mem_we      = 1'b0;
    ready       = 1'b0;

    case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) begin
          idx_d   = offset[IW+1:2];
          wdata_d = write_data;
          store_d = MEM_W_EN;
          bad_d   = req_bad;
          both_d  = MEM_R_EN & MEM_W_EN;
          cnt_d   = CW'(WAIT_CYCLES - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d    = DONE;
          addr_err_d = bad_q | both_q;
          if (store_q) begin
            mem_we = ~bad_q;
          end else begin
            read_data_d = bad_q ? 32'd0 : mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      store_q     <= 1'b0;
      bad_q       <= 1'b0;
      both_q      <= 1'b0;
      read_data_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      store_q     <= store_d;
      bad_q       <= bad_d;
      both_q      <= both_d;
      read_data_q <= read_data_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // RAM contents survive reset; mem_we is gated by state_q, so a reset mid-BUSY drops the write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign read_data = read_data_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
// Driver pushes expected DONE-cycle results; a negedge monitor pops and compares on each DONE.
module tb_data_mem_responder;

  localparam int W = 3;

  logic        clk;
  logic        rst;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        addr_err;

  data_mem_responder #(.WAIT_CYCLES(W), .DEPTH(64), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready), .addr_err(addr_err)
  );

  typedef struct {
    logic        is_load;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_timeout", ready, {31'd0, ready}, 32'd1);
  endtask

  // Request presented in IDLE for one edge; returns in the IDLE cycle after DONE.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_d, input logic exp_e, input logic corrupt);
    exp_t e;
    e.is_load = r & ~w;
    e.data    = exp_d;
    e.err     = exp_e;
    sb.push_back(e);
    MEM_R_EN = r; MEM_W_EN = w; address = a; write_data = d;
    @(posedge clk); #1;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    if (corrupt) begin
      address = a + 32'd4; write_data = 32'd0;
    end
    wait_done();
    @(posedge clk); #1;
  endtask

  // Monitor: a DONE cycle is the first ready-high cycle after a ready-low run.
  initial begin
    logic prev;
    int   low;
    exp_t e;
    prev = 1'b1;
    low  = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b1;
        low  = 0;
      end else begin
        if (ready && !prev) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1'b0, 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("ready_low_cycles", low == W + 1, 32'(low), 32'(W + 1));
            check("addr_err_in_done", addr_err == e.err, {31'd0, addr_err}, {31'd0, e.err});
            if (e.is_load) check("read_data", read_data === e.data, read_data, e.data);
          end
        end else begin
          check("addr_err_outside_done", addr_err == 1'b0, {31'd0, addr_err}, 32'd0);
        end
        low  = ready ? 0 : low + 1;
        prev = ready;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = 32'd0; write_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_read_data", read_data === 32'd0, read_data, 32'd0);
    check("reset_addr_err", addr_err === 1'b0, {31'd0, addr_err}, 32'd0);
    check("reset_ready", ready === 1'b1, {31'd0, ready}, 32'd1);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ready !== 1'b1) n++;
    end
    check("idle_ready_10", n == 0, 32'(n), 32'd0);

    // Known background values
    do_access(1'b0, 1'b1, 32'd1024, 32'hCAFE0000, 32'd0, 1'b0, 1'b0);
    do_access(1'b0, 1'b1, 32'd1040, 32'h0BADF00D, 32'd0, 1'b0, 1'b0);
    do_access(1'b0, 1'b1, 32'd1036, 32'h13572468, 32'd0, 1'b0, 1'b0);

    do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
    do_access(1'b1, 1'b0, 32'd1028, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0);

    do_access(1'b0, 1'b1, 32'd1020, 32'h11, 32'd0, 1'b1, 1'b0);
    do_access(1'b1, 1'b0, 32'd1024, 32'd0, 32'hCAFE0000, 1'b0, 1'b0);
    do_access(1'b1, 1'b0, 32'd1280, 32'd0, 32'd0, 1'b1, 1'b0);
    do_access(1'b1, 1'b0, 32'd1028, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0);
    do_access(1'b1, 1'b0, 32'd1026, 32'd0, 32'd0, 1'b1, 1'b0);

    do_access(1'b0, 1'b1, 32'd1032, 32'hA5A5A5A5, 32'd0, 1'b0, 1'b1);
    do_access(1'b1, 1'b0, 32'd1032, 32'd0, 32'hA5A5A5A5, 1'b0, 1'b0);
    do_access(1'b1, 1'b0, 32'd1036, 32'd0, 32'h13572468, 1'b0, 1'b0);

    // Reset in the second BUSY cycle of a store
    MEM_W_EN = 1'b1; address = 32'd1040; write_data = 32'h12345678;
    @(posedge clk); #1;
    MEM_W_EN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("async_reset_ready", ready === 1'b1, {31'd0, ready}, 32'd1);
    check("async_reset_read_data", read_data === 32'd0, read_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 32'd1040, 32'd0, 32'h0BADF00D, 1'b0, 1'b0);

    do_access(1'b1, 1'b1, 32'd1044, 32'h77, 32'd0, 1'b1, 1'b0);
    do_access(1'b1, 1'b0, 32'd1044, 32'd0, 32'h77, 1'b0, 1'b0);

    // Three loads with the request held high, next address presented in each DONE cycle
    sb.push_back('{1'b1, 32'hCAFE0000, 1'b0});
    sb.push_back('{1'b1, 32'hDEADBEEF, 1'b0});
    sb.push_back('{1'b1, 32'hA5A5A5A5, 1'b0});
    MEM_R_EN = 1'b1; address = 32'd1024;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!ready && n < 20);
      check("b2b_done_timeout", ready, {31'd0, ready}, 32'd1);
      if (k == 0) address = 32'd1028;
      else if (k == 1) address = 32'd1032;
      else MEM_R_EN = 1'b0;
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size() == 0, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
